// File: rtl/axi_mem_pkg.sv
// Shared definitions for the AXI4-Lite backing memory bank: response codes
// and the byte-strobe merge used by the read-during-write bypass.
package axi_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Widest data word the merge helper handles; callers zero-extend into it.
  localparam int unsigned MERGE_MAX_W = 512;
  localparam int unsigned MERGE_MAX_B = MERGE_MAX_W / 8;

  // Replace each byte of old_word whose strobe bit is set with the same byte of new_word.
  function automatic logic [MERGE_MAX_W-1:0] strb_merge(
    input logic [MERGE_MAX_W-1:0] old_word,
    input logic [MERGE_MAX_W-1:0] new_word,
    input logic [MERGE_MAX_B-1:0] strb
  );
    logic [MERGE_MAX_W-1:0] merged;
    merged = old_word;
    for (int unsigned b = 0; b < MERGE_MAX_B; b++) begin
      if (strb[b]) begin
        merged[b*8 +: 8] = new_word[b*8 +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/axi_mem_rsp_fifo.sv
// Read response buffer: a small circular FIFO of any depth >= 2.
// Pop on empty is ignored; push on full is accepted only alongside a pop.
module axi_mem_rsp_fifo #(
  parameter int unsigned width = 34,
  parameter int unsigned depth = 3,
  localparam int unsigned PTR_W = $clog2(depth),
  localparam int unsigned CNT_W = $clog2(depth + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output logic [width-1:0] head
);

  logic [width-1:0] r_store [depth];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;
  logic             w_push;

  assign w_pop  = pop && (r_count != '0);
  assign w_push = push && ((r_count != CNT_W'(depth)) || w_pop);

  // Pointers wrap at depth-1 so non-power-of-2 depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(depth - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < depth; i++) begin
        r_store[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_store[r_wr_ptr] <= push_data;
        r_wr_ptr          <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign count = r_count;
  assign head  = r_store[r_rd_ptr];

endmodule

// File: rtl/axi_mem_bank.sv
// Single-port AXI4-Lite backing memory: byte-strobed writes with range
// error pulse, and a two-stage read pipeline feeding an output buffer so
// that RREADY backpressure never loses a response.
module axi_mem_bank
  import axi_mem_pkg::*;
#(
  parameter int unsigned dataWidth = 32,
  parameter int unsigned dataDepth = 64,
  parameter int unsigned addrWidth = $clog2(dataDepth),
  parameter int unsigned strbWidth = dataWidth / 8,
  parameter int unsigned outDepth  = 3,
  parameter int unsigned rdwMode   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 WEN,
  input  logic [addrWidth-1:0] AWADDR,
  input  logic [strbWidth-1:0] WSTRB,
  input  logic [dataWidth-1:0] WDATA,
  output logic                 WERR,
  input  logic                 REN,
  input  logic [addrWidth-1:0] ARADDR,
  output logic                 ARREADY,
  output logic                 RVALID,
  input  logic                 RREADY,
  output logic [dataWidth-1:0] RDATA,
  output logic [1:0]           RRESP
);

  localparam int unsigned CNT_W = $clog2(outDepth + 1);
  localparam int unsigned OCC_W = CNT_W + 1;
  localparam int unsigned ENT_W = dataWidth + 2;
  localparam logic [addrWidth:0] DEPTH_EXT = (addrWidth + 1)'(dataDepth);
  localparam logic [OCC_W-1:0]   OCC_LIMIT = OCC_W'(outDepth);

  logic [dataWidth-1:0] r_mem [dataDepth];

  logic                 r_werr;
  logic                 r_arready;
  logic                 r_s1_valid;
  logic [dataWidth-1:0] r_s1_data;
  logic                 r_s1_err;

  logic                 w_wr_in_range;
  logic                 w_rd_in_range;
  logic                 w_wr_en;
  logic [addrWidth-1:0] w_wr_idx;
  logic [addrWidth-1:0] w_rd_idx;
  logic [dataWidth-1:0] w_rd_old;
  logic [dataWidth-1:0] w_rdw_merged;
  logic [dataWidth-1:0] w_rd_word;
  logic                 w_same_addr;
  logic                 w_accept;
  logic                 w_rvalid;
  logic                 w_pop;
  logic [CNT_W-1:0]     w_fifo_count;
  logic [ENT_W-1:0]     w_fifo_head;
  logic [ENT_W-1:0]     w_s1_entry;
  logic [OCC_W-1:0]     w_occ_next;

  // Range checks; out-of-range addresses are clamped to 0 so the array is never over-indexed.
  assign w_wr_in_range = ({1'b0, AWADDR} < DEPTH_EXT);
  assign w_rd_in_range = ({1'b0, ARADDR} < DEPTH_EXT);
  assign w_wr_idx      = w_wr_in_range ? AWADDR : '0;
  assign w_rd_idx      = w_rd_in_range ? ARADDR : '0;
  assign w_wr_en       = WEN && w_wr_in_range;

  // Read word selection, including the same-address read-during-write bypass.
  assign w_rd_old     = r_mem[w_rd_idx];
  assign w_rdw_merged = dataWidth'(strb_merge(MERGE_MAX_W'(w_rd_old),
                                              MERGE_MAX_W'(WDATA),
                                              MERGE_MAX_B'(WSTRB)));
  assign w_same_addr  = w_wr_en && (AWADDR == ARADDR);
  assign w_rd_word    = !w_rd_in_range                    ? '0 :
                        ((rdwMode != 0) && w_same_addr)   ? w_rdw_merged :
                                                            w_rd_old;

  assign w_accept = REN && r_arready;
  assign w_rvalid = (w_fifo_count != '0);
  assign w_pop    = w_rvalid && RREADY;

  // Occupancy (buffer + stage 1) after this edge; decides next-cycle ARREADY.
  assign w_occ_next = OCC_W'(w_fifo_count) + OCC_W'(r_s1_valid)
                    + OCC_W'(w_accept) - OCC_W'(w_pop);

  // Byte-enabled storage write; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int unsigned b = 0; b < strbWidth; b++) begin
        if (WSTRB[b]) begin
          r_mem[w_wr_idx][b*8 +: 8] <= WDATA[b*8 +: 8];
        end
      end
    end
  end

  // Write error pulse, stage-1 read capture and registered ARREADY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_werr     <= 1'b0;
      r_arready  <= 1'b1;
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_err   <= 1'b0;
    end else begin
      r_werr     <= WEN && !w_wr_in_range;
      r_arready  <= (w_occ_next < OCC_LIMIT);
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_data <= w_rd_word;
        r_s1_err  <= !w_rd_in_range;
      end
    end
  end

  assign w_s1_entry = {(r_s1_err ? RESP_SLVERR : RESP_OKAY), r_s1_data};

  axi_mem_rsp_fifo #(
    .width (ENT_W),
    .depth (outDepth)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (r_s1_valid),
    .push_data (w_s1_entry),
    .pop       (w_pop),
    .count     (w_fifo_count),
    .head      (w_fifo_head)
  );

  assign WERR    = r_werr;
  assign ARREADY = r_arready;
  assign RVALID  = w_rvalid;
  assign RDATA   = w_fifo_head[dataWidth-1:0];
  assign RRESP   = w_fifo_head[dataWidth+1:dataWidth];

endmodule

// File: tb/tb_axi_mem_bank.sv
// Scoreboard bench for axi_mem_bank. Two instances (rdwMode 0 and 1,
// dataDepth 48) share all inputs; each has its own expected-response queue
// and monitor.
module tb_axi_mem_bank;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 48;
  localparam int unsigned AW    = 6;
  localparam int unsigned SW    = 4;

  logic          clk;
  logic          reset;
  logic          wen;
  logic [AW-1:0] awaddr;
  logic [SW-1:0] wstrb;
  logic [DW-1:0] wdata;
  logic          ren;
  logic [AW-1:0] araddr;
  logic          rready;

  logic          werr_a, arready_a, rvalid_a;
  logic [DW-1:0] rdata_a;
  logic [1:0]    rresp_a;
  logic          werr_b, arready_b, rvalid_b;
  logic [DW-1:0] rdata_b;
  logic [1:0]    rresp_b;

  axi_mem_bank #(.dataWidth(DW), .dataDepth(DEPTH), .outDepth(3), .rdwMode(0)) dut_a (
    .clk(clk), .reset(reset),
    .WEN(wen), .AWADDR(awaddr), .WSTRB(wstrb), .WDATA(wdata), .WERR(werr_a),
    .REN(ren), .ARADDR(araddr), .ARREADY(arready_a),
    .RVALID(rvalid_a), .RREADY(rready), .RDATA(rdata_a), .RRESP(rresp_a)
  );

  axi_mem_bank #(.dataWidth(DW), .dataDepth(DEPTH), .outDepth(3), .rdwMode(1)) dut_b (
    .clk(clk), .reset(reset),
    .WEN(wen), .AWADDR(awaddr), .WSTRB(wstrb), .WDATA(wdata), .WERR(werr_b),
    .REN(ren), .ARADDR(araddr), .ARREADY(arready_b),
    .RVALID(rvalid_b), .RREADY(rready), .RDATA(rdata_b), .RRESP(rresp_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    resp;
    int            cyc;
    bit            exact;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [DW-1:0] nx_a, nx_b;
  logic [1:0]    nx_resp;
  bit            nx_exact;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Push the expected response whenever a read is accepted.
  always @(posedge clk) begin
    exp_t e;
    e.data  = nx_a;
    e.resp  = nx_resp;
    e.cyc   = cyc;
    e.exact = nx_exact;
    if (!reset && ren && arready_a) q_a.push_back(e);
    e.data = nx_b;
    if (!reset && ren && arready_b) q_b.push_back(e);
    cyc++;
  end

  // Monitor for instance A: in-order compare, latency, stall stability.
  logic [33:0] prev_a;
  bit          stall_a = 0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      stall_a = 0;
    end else begin
      if (stall_a) check("a_hold_stable", {rresp_a, rdata_a}, prev_a);
      if (rvalid_a && rready) begin
        if (q_a.size() == 0) begin
          check("a_unexpected_rvalid", 1, 0);
        end else begin
          e = q_a.pop_front();
          check("a_rdata", rdata_a, e.data);
          check("a_rresp", rresp_a, e.resp);
          if (e.exact) check("a_latency", cyc, e.cyc + 2);
        end
      end
      stall_a = rvalid_a && !rready;
      prev_a  = {rresp_a, rdata_a};
    end
  end

  // Monitor for instance B.
  logic [33:0] prev_b;
  bit          stall_b = 0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      stall_b = 0;
    end else begin
      if (stall_b) check("b_hold_stable", {rresp_b, rdata_b}, prev_b);
      if (rvalid_b && rready) begin
        if (q_b.size() == 0) begin
          check("b_unexpected_rvalid", 1, 0);
        end else begin
          e = q_b.pop_front();
          check("b_rdata", rdata_b, e.data);
          check("b_rresp", rresp_b, e.resp);
          if (e.exact) check("b_latency", cyc, e.cyc + 2);
        end
      end
      stall_b = rvalid_b && !rready;
      prev_b  = {rresp_b, rdata_b};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    wen    = 1'b1;
    awaddr = AW'(a);
    wdata  = d;
    wstrb  = s;
    step();
    wen = 1'b0;
  endtask

  // Issue one read and hold it until accepted (bounded).
  task automatic rd(input int a, input logic [DW-1:0] ea, input logic [DW-1:0] eb,
                    input logic [1:0] r, input bit ex);
    bit acc;
    acc      = 0;
    nx_a     = ea;
    nx_b     = eb;
    nx_resp  = r;
    nx_exact = ex;
    araddr   = AW'(a);
    ren      = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      acc = arready_a;
      step();
    end
    ren = 1'b0;
    if (!acc) check("rd_accept_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (q_a.size() != 0 || q_b.size() != 0); i++) step();
    check("drain_a_empty", q_a.size(), 0);
    check("drain_b_empty", q_b.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    reset = 1'b1; wen = 0; awaddr = '0; wstrb = '0; wdata = '0;
    ren = 0; araddr = '0; rready = 0;
    nx_a = '0; nx_b = '0; nx_resp = '0; nx_exact = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    step();

    // Reset state
    check("rst_werr",    werr_a,    0);
    check("rst_rvalid",  rvalid_a,  0);
    check("rst_arready", arready_a, 1);
    check("rst_rdata",   rdata_a,   0);
    check("rst_rresp",   rresp_a,   0);
    check("rst_arready_b", arready_b, 1);

    // Strobe merge and first-response latency
    rready = 1'b1;
    wr(5, 32'hDEADBEEF, 4'b1111);
    wr(5, 32'h11223344, 4'b0101);
    rd(5, 32'hDE22BE44, 32'hDE22BE44, 2'b00, 1);
    drain();

    // Range errors and boundaries (depth 48)
    wr(2,  32'h0BADF00D, 4'b1111);
    wr(47, 32'h47474747, 4'b1111);
    check("werr_inrange", werr_a, 0);
    wr(50, 32'hFFFFFFFF, 4'b1111);
    check("werr_oor_a", werr_a, 1);
    check("werr_oor_b", werr_b, 1);
    step();
    check("werr_one_cycle", werr_a, 0);
    wr(48, 32'hFFFFFFFF, 4'b1111);
    check("werr_depth_edge", werr_a, 1);
    wr(2, 32'hFFFFFFFF, 4'b0000);
    check("werr_strb0", werr_a, 0);
    rd(50, 32'h0, 32'h0, 2'b10, 1);
    rd(48, 32'h0, 32'h0, 2'b10, 1);
    rd(2,  32'h0BADF00D, 32'h0BADF00D, 2'b00, 1);
    rd(47, 32'h47474747, 32'h47474747, 2'b00, 1);
    drain();

    // Backpressure: three accepts then ARREADY low until RREADY returns
    for (int i = 0; i < 4; i++) wr(i, 32'hC0DE0000 + 32'(i), 4'b1111);
    rready = 1'b0;
    for (int i = 0; i < 3; i++) rd(i, 32'hC0DE0000 + 32'(i), 32'hC0DE0000 + 32'(i), 2'b00, 0);
    check("arready_full", arready_a, 0);
    nx_a = 32'hC0DE0003; nx_b = 32'hC0DE0003; nx_resp = 2'b00; nx_exact = 0;
    araddr = AW'(3);
    ren    = 1'b1;
    repeat (4) step();
    check("arready_held_a", arready_a, 0);
    check("arready_held_b", arready_b, 0);
    check("rvalid_stalled", rvalid_a, 1);
    rready = 1'b1;
    rd(3, 32'hC0DE0003, 32'hC0DE0003, 2'b00, 0);
    drain();

    // Full throughput: 16 back-to-back reads
    for (int i = 0; i < 16; i++) wr(10 + i, 32'hA5000000 + 32'(i * 7), 4'b1111);
    start = cyc;
    for (int i = 0; i < 16; i++)
      rd(10 + i, 32'hA5000000 + 32'(i * 7), 32'hA5000000 + 32'(i * 7), 2'b00, 1);
    check("b2b_cycles", cyc - start, 16);
    drain();

    // Read-during-write, same address
    wr(7, 32'h12345678, 4'b1111);
    wen = 1'b1; awaddr = AW'(7); wdata = 32'hAAAA5555; wstrb = 4'b0011;
    rd(7, 32'h12345678, 32'h12345555, 2'b00, 1);
    wen = 1'b0;
    rd(7, 32'h12345555, 32'h12345555, 2'b00, 1);
    drain();

    // Reset with reads in flight
    wr(9, 32'hCAFEF00D, 4'b1111);
    rready = 1'b0;
    rd(9, 32'hCAFEF00D, 32'hCAFEF00D, 2'b00, 0);
    rd(9, 32'hCAFEF00D, 32'hCAFEF00D, 2'b00, 0);
    check("pre_reset_rvalid", rvalid_a, 1);
    #2;
    reset = 1'b1;
    q_a.delete();
    q_b.delete();
    #1;
    check("async_rvalid_a", rvalid_a, 0);
    check("async_rvalid_b", rvalid_b, 0);
    check("async_rdata",    rdata_a,  0);
    step();
    step();
    reset = 1'b0;
    check("post_rst_arready", arready_a, 1);
    check("post_rst_rvalid",  rvalid_a,  0);
    rready = 1'b1;
    repeat (6) step();
    check("no_stale_a", rvalid_a, 0);
    check("no_stale_b", rvalid_b, 0);
    rd(9, 32'hCAFEF00D, 32'hCAFEF00D, 2'b00, 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
